// File: rtl/pll_ctrl_pkg.sv
// Shared types and default constants for the PLL reset controller.
// Fixed state encoding is visible on the debug state port.
package pll_ctrl_pkg;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam int unsigned DEF_RST_CYCLES    = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT  = 100000;
  localparam int unsigned DEF_STABLE_CYCLES = 1024;
  localparam int unsigned DEF_SYNC_STAGES   = 2;
  localparam int unsigned DEF_CNT_W         = 8;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Multi-stage synchroniser bringing the asynchronous PLL locked flag into refclk.
// Async active-low reset clears every stage.
module pll_lock_sync
  import pll_ctrl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain <= '0;
    else        chain <= {chain[SYNC_STAGES-2:0], async_in};
  end

  assign sync_out = chain[SYNC_STAGES-1];

endmodule

// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock, then releases
// the system reset; re-arms on timeout, lock loss or software request.
module pll_reset_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             pll_locked,
  input  logic             sw_rst_req,
  input  logic             clr_status,
  output logic             pll_rst,
  output logic             sys_rst_n,
  output logic             ready,
  output logic             lock_lost,
  output logic [CNT_W-1:0] lock_loss_cnt,
  output logic [CNT_W-1:0] timeout_cnt,
  output logic [1:0]       state
);

  localparam int unsigned CYC_MAX = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int unsigned CYC_W   = $clog2(CYC_MAX + 1);

  localparam logic [CYC_W-1:0] RST_LAST    = CYC_W'(RST_CYCLES - 1);
  localparam logic [CYC_W-1:0] TO_LAST     = CYC_W'(LOCK_TIMEOUT - 1);
  localparam logic [CYC_W-1:0] STABLE_LAST = CYC_W'(STABLE_CYCLES - 1);

  state_t           cur_state, nxt_state;
  logic [CYC_W-1:0] cyc;
  logic             cyc_clr;
  logic             locked_s;
  logic             timeout_evt, loss_evt;
  logic             pll_rst_d, run_d;

  pll_lock_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk      (refclk),
    .rst_n    (rst_n),
    .async_in (pll_locked),
    .sync_out (locked_s)
  );

  // State register and shared cycle counter
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= PLL_RST;
      cyc       <= '0;
    end else begin
      cur_state <= nxt_state;
      if (cyc_clr)              cyc <= '0;
      else if (cur_state != RUN) cyc <= cyc + CYC_W'(1);
    end
  end

  // Next-state logic; software request overrides everything and logs no event
  always_comb begin
    nxt_state   = cur_state;
    timeout_evt = 1'b0;
    loss_evt    = 1'b0;
    if (sw_rst_req) begin
      nxt_state = PLL_RST;
    end else begin
      unique case (cur_state)
        PLL_RST: begin
          if (cyc == RST_LAST) nxt_state = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            nxt_state = STABLE;
          end else if (cyc == TO_LAST) begin
            nxt_state   = PLL_RST;
            timeout_evt = 1'b1;
          end
        end
        STABLE: begin
          if (!locked_s)                nxt_state = WAIT_LOCK;
          else if (cyc == STABLE_LAST)  nxt_state = RUN;
        end
        RUN: begin
          if (!locked_s) begin
            nxt_state = PLL_RST;
            loss_evt  = 1'b1;
          end
        end
        default: nxt_state = PLL_RST;
      endcase
    end
    cyc_clr = sw_rst_req || (nxt_state != cur_state);
  end

  // Outputs decoded from the next state so they update with the state register
  always_comb begin
    pll_rst_d = (nxt_state == PLL_RST);
    run_d     = (nxt_state == RUN);
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      ready     <= 1'b0;
    end else begin
      pll_rst   <= pll_rst_d;
      sys_rst_n <= run_d;
      ready     <= run_d;
    end
  end

  // Sticky status; a clear coinciding with an event leaves that event recorded
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      lock_lost     <= 1'b0;
      lock_loss_cnt <= '0;
      timeout_cnt   <= '0;
    end else if (clr_status) begin
      lock_lost     <= loss_evt;
      lock_loss_cnt <= CNT_W'(loss_evt);
      timeout_cnt   <= CNT_W'(timeout_evt);
    end else begin
      if (loss_evt) lock_lost <= 1'b1;
      if (loss_evt && (lock_loss_cnt != '1))
        lock_loss_cnt <= lock_loss_cnt + CNT_W'(1);
      if (timeout_evt && (timeout_cnt != '1))
        timeout_cnt <= timeout_cnt + CNT_W'(1);
    end
  end

  assign state = cur_state;

endmodule
